// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states
// and the byte count of each access size.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   function automatic logic [2:0] nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: nbytes = 3'd1;
         SZ_HALF: nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Lane logic shared by loads and stores: low-byte extract with sign/zero
// extension, and merge of store data into the low bytes of a read word.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] rd,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   always_comb begin
      load_data = rd;
      merged    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & rd[7]}}, rd[7:0]};
            merged    = {rd[31:8], wdata[7:0]};
         end
         SZ_HALF: begin
            load_data = {{16{sign_ext & rd[15]}}, rd[15:0]};
            merged    = {rd[31:16], wdata[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressable data memory; sub-word stores
// are done as read-modify-write of the word at the (unaligned) address.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory addressed; load/merge data captured, word store written
// WRITE  | merged sub-word store written back
// RESP   | one-cycle response pulse
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BYTE_SIZE  = 4,
   parameter int MEM_BYTES  = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [31:0]           rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [31:0]           mem_wd,
   input  logic [31:0]           mem_rd
);

   localparam int WORD_BITS = 8 * BYTE_SIZE;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [1:0]              size_q;
   logic                    signed_q;
   logic                    we_q;
   logic [WORD_BITS-1:0]    wdata_q;
   logic [WORD_BITS-1:0]    merge_q;
   logic [31:0]             load_data;
   logic [31:0]             merged;
   logic [ADDR_WIDTH:0]     end_addr;
   logic                    accept;
   logic                    req_err;

   assign accept = req_valid && req_ready;

   // One extra bit so an address near the top of the space cannot wrap into range.
   assign end_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(nbytes(req_size));
   assign req_err  = (req_size == SZ_ILL) || (end_addr > (ADDR_WIDTH+1)'(MEM_BYTES));

   mem_align u_align (
      .size      (size_q),
      .sign_ext  (signed_q),
      .rd        (mem_rd),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   // Memory pins decode from state so an async reset drops mem_we at once.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      case (state)
         ACCESS: begin
            mem_addr = addr_q;
            if (we_q && size_q == SZ_WORD) begin
               mem_we = 1'b1;
               mem_wd = wdata_q;
            end
         end
         WRITE: begin
            mem_we   = 1'b1;
            mem_addr = addr_q;
            mem_wd   = merge_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         signed_q  <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         merge_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q    <= req_addr;
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  we_q      <= req_we;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (req_err) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (size_q == SZ_WORD) begin
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  merge_q <= merged;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural byte memory and
// a scoreboard of expected responses predicted from a shadow copy of memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   mem_access_unit #(.ADDR_WIDTH(32), .BYTE_SIZE(4), .MEM_BYTES(128)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_rdata  (rsp_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nwe;
      logic [31:0] wd;
   } exp_t;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wd;
   } req_t;

   exp_t        sb[$];
   logic [7:0]  mem[128];
   logic [7:0]  ref_mem[128];
   logic        pre_en = 1'b0;
   logic [6:0]  pre_a  = '0;
   logic [7:0]  pre_d  = '0;
   int          we_cnt  = 0;
   int          rsp_cnt = 0;
   int          acc_cnt = 0;
   logic [31:0] last_wd = '0;
   int          vectors = 0;
   int          miscompares = 0;

   // Memory: combinational 4-byte read, full-word write; bytes past the end read 0.
   always_comb begin
      mem_rd = '0;
      for (int i = 0; i < 4; i++) begin
         logic [32:0] a;
         a = {1'b0, mem_addr} + 33'(i);
         if (a < 33'd128) mem_rd[8*i +: 8] = mem[a[6:0]];
      end
   end

   always @(posedge clk) begin
      if (mem_we) begin
         we_cnt++;
         last_wd = mem_wd;
         for (int i = 0; i < 4; i++) begin
            logic [32:0] a;
            a = {1'b0, mem_addr} + 33'(i);
            if (a < 33'd128) mem[a[6:0]] = mem_wd[8*i +: 8];
         end
      end
      if (pre_en) mem[pre_a] = pre_d;
      if (rsp_valid) rsp_cnt++;
      if (req_valid && req_ready) acc_cnt++;
   end

   function automatic logic [7:0] rbyte(input longint unsigned a);
      return (a < 128) ? ref_mem[a[6:0]] : 8'h00;
   endfunction

   // Reference model: computes the response and updates shadow memory on stores.
   task automatic predict(input req_t r);
      exp_t e;
      int nb;
      longint unsigned base;
      logic [31:0] w;
      nb = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
      base = r.addr;
      w = {rbyte(base + 3), rbyte(base + 2), rbyte(base + 1), rbyte(base)};
      e.err = (r.size == 2'd3) || (base + longint'(nb) > 128);
      e.rdata = 32'h0;
      e.nwe = 0;
      e.wd = 32'h0;
      if (e.err) begin
         e.lat = 1;
      end else if (!r.we) begin
         e.lat = 2;
         if (r.size == 2'd0)
            e.rdata = (r.sg && w[7]) ? {24'hFFFFFF, w[7:0]} : {24'h0, w[7:0]};
         else if (r.size == 2'd1)
            e.rdata = (r.sg && w[15]) ? {16'hFFFF, w[15:0]} : {16'h0, w[15:0]};
         else
            e.rdata = w;
      end else begin
         e.lat = (r.size == 2'd2) ? 2 : 3;
         e.nwe = 1;
         e.wd = w;
         for (int i = 0; i < nb; i++) begin
            e.wd[8*i +: 8] = r.wd[8*i +: 8];
            if (base + longint'(i) < 128) ref_mem[int'(base) + i] = r.wd[8*i +: 8];
         end
      end
      sb.push_back(e);
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      pre_a = a[6:0];
      pre_d = d;
      pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
      ref_mem[a] = d;
   endtask

   function automatic int mem_diffs();
      int bad = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
      return bad;
   endfunction

   task automatic drive(input req_t r);
      req_we = r.we;
      req_size = r.size;
      req_signed = r.sg;
      req_addr = r.addr;
      req_wdata = r.wd;
      req_valid = 1'b1;
   endtask

   // Issues one request, predicts at acceptance, observes the response.
   task automatic run_txn(input req_t r, output int lat, output logic err,
                          output logic [31:0] rdata, output int nwe,
                          output logic [31:0] wdo, output logic [32:0] post);
      int g;
      int w0;
      drive(r);
      g = 0;
      while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
      w0 = we_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      predict(r);
      lat = 1;
      while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      err = rsp_err;
      rdata = rsp_rdata;
      nwe = we_cnt - w0;
      wdo = last_wd;
      @(posedge clk); #1;
      post = {rsp_valid, rsp_rdata};
   endtask

   task automatic test_reset();
      vectors++;
      if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
         $display("FAIL reset_ctrl: got %b want 1000", {req_ready, rsp_valid, rsp_err, mem_we});
         miscompares++;
      end
      vectors++;
      if ({rsp_rdata, mem_addr, mem_wd} !== 96'h0) begin
         $display("FAIL reset_data: got rdata=%h addr=%h wd=%h want 0", rsp_rdata, mem_addr, mem_wd);
         miscompares++;
      end
   endtask

   task automatic test_loads();
      req_t tbl[6] = '{
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0},
         '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0},
         '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0},
         '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0},
         '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0},
         '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0}
      };
      int lat, nwe;
      logic err;
      logic [31:0] rdata, wdo;
      logic [32:0] post;
      exp_t e;
      foreach (tbl[i]) begin
         run_txn(tbl[i], lat, err, rdata, nwe, wdo, post);
         e = sb.pop_front();
         vectors += 5;
         if (lat !== e.lat) begin
            $display("FAIL load[%0d] latency: got %0d want %0d", i, lat, e.lat); miscompares++;
         end
         if (err !== e.err) begin
            $display("FAIL load[%0d] err: got %b want %b", i, err, e.err); miscompares++;
         end
         if (rdata !== e.rdata) begin
            $display("FAIL load[%0d] rdata: got %h want %h", i, rdata, e.rdata); miscompares++;
         end
         if (nwe !== e.nwe) begin
            $display("FAIL load[%0d] mem_we cycles: got %0d want %0d", i, nwe, e.nwe); miscompares++;
         end
         if (post !== 33'h0) begin
            $display("FAIL load[%0d] pulse end: got valid/rdata %h want 0", i, post); miscompares++;
         end
      end
   endtask

   task automatic test_stores();
      req_t tbl[9] = '{
         '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB},
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0},
         '{1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF},
         '{1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D},
         '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0},
         '{1'b0, 2'd0, 1'b1, 32'h22, 32'h0},
         '{1'b1, 2'd1, 1'b0, 32'h7E, 32'h1234ABCD},
         '{1'b1, 2'd0, 1'b0, 32'h7F, 32'hFFFFFF77},
         '{1'b0, 2'd1, 1'b0, 32'h7E, 32'h0}
      };
      int lat, nwe, bad;
      logic err;
      logic [31:0] rdata, wdo;
      logic [32:0] post;
      exp_t e;
      foreach (tbl[i]) begin
         run_txn(tbl[i], lat, err, rdata, nwe, wdo, post);
         e = sb.pop_front();
         vectors += 4;
         if (lat !== e.lat) begin
            $display("FAIL store[%0d] latency: got %0d want %0d", i, lat, e.lat); miscompares++;
         end
         if (err !== e.err) begin
            $display("FAIL store[%0d] err: got %b want %b", i, err, e.err); miscompares++;
         end
         if (rdata !== e.rdata) begin
            $display("FAIL store[%0d] rdata: got %h want %h", i, rdata, e.rdata); miscompares++;
         end
         if (nwe !== e.nwe) begin
            $display("FAIL store[%0d] mem_we cycles: got %0d want %0d", i, nwe, e.nwe); miscompares++;
         end
         if (e.nwe == 1) begin
            vectors++;
            if (wdo !== e.wd) begin
               $display("FAIL store[%0d] mem_wd: got %h want %h", i, wdo, e.wd); miscompares++;
            end
         end
      end
      bad = mem_diffs();
      vectors++;
      if (bad !== 0) begin
         $display("FAIL store memory image: got %0d differing bytes want 0", bad); miscompares++;
      end
   endtask

   task automatic test_errors();
      req_t tbl[7] = '{
         '{1'b0, 2'd2, 1'b0, 32'h7D, 32'h0},
         '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0},
         '{1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678},
         '{1'b1, 2'd1, 1'b0, 32'h7F, 32'h0000A5A5},
         '{1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0},
         '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hDEADBEEF},
         '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0}
      };
      int lat, nwe, bad;
      logic err;
      logic [31:0] rdata, wdo;
      logic [32:0] post;
      exp_t e;
      foreach (tbl[i]) begin
         run_txn(tbl[i], lat, err, rdata, nwe, wdo, post);
         e = sb.pop_front();
         vectors += 4;
         if (lat !== e.lat) begin
            $display("FAIL err[%0d] latency: got %0d want %0d", i, lat, e.lat); miscompares++;
         end
         if (err !== e.err) begin
            $display("FAIL err[%0d] err: got %b want %b", i, err, e.err); miscompares++;
         end
         if (rdata !== e.rdata) begin
            $display("FAIL err[%0d] rdata: got %h want %h", i, rdata, e.rdata); miscompares++;
         end
         if (nwe !== e.nwe) begin
            $display("FAIL err[%0d] mem_we cycles: got %0d want %0d", i, nwe, e.nwe); miscompares++;
         end
      end
      bad = mem_diffs();
      vectors++;
      if (bad !== 0) begin
         $display("FAIL err memory image: got %0d differing bytes want 0", bad); miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      req_t r = '{1'b1, 2'd1, 1'b0, 32'h30, 32'h00001234};
      int g, r0, bad;
      drive(r);
      g = 0;
      while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
      r0 = rsp_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      g = 0;
      while (!mem_we && g < 5) begin @(posedge clk); #1; g++; end
      vectors++;
      if (mem_we !== 1'b1) begin
         $display("FAIL rst_mid reach WRITE: got mem_we=%b want 1", mem_we); miscompares++;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (mem_we !== 1'b0) begin
         $display("FAIL rst_mid async we drop: got %b want 0", mem_we); miscompares++;
      end
      vectors++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wd} !== {3'b100, 96'h0}) begin
         $display("FAIL rst_mid outputs: got ready=%b v=%b e=%b rd=%h a=%h wd=%h want reset values",
                  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wd);
         miscompares++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         $display("FAIL rst_mid ready after release: got %b want 1", req_ready); miscompares++;
      end
      vectors++;
      if (rsp_cnt - r0 !== 0) begin
         $display("FAIL rst_mid response count: got %0d want 0", rsp_cnt - r0); miscompares++;
      end
      bad = mem_diffs();
      vectors++;
      if (bad !== 0) begin
         $display("FAIL rst_mid memory image: got %0d differing bytes want 0", bad); miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      req_t tbl[3] = '{
         '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0},
         '{1'b1, 2'd0, 1'b0, 32'h41, 32'h0000005A},
         '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0}
      };
      int a0, r0;
      a0 = acc_cnt;
      r0 = rsp_cnt;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               int g;
               drive(tbl[k]);
               g = 0;
               while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
               @(posedge clk); #1;
               predict(tbl[k]);
            end
            req_valid = 1'b0;
         end
         begin
            int n;
            int cyc;
            exp_t e;
            n = 0;
            cyc = 0;
            while (n < 3 && cyc < 60) begin
               @(negedge clk);
               cyc++;
               if (rsp_valid) begin
                  vectors += 3;
                  if (sb.size() == 0) begin
                     $display("FAIL b2b[%0d] response with empty scoreboard", n); miscompares++;
                  end else begin
                     e = sb.pop_front();
                     if (rsp_err !== e.err) begin
                        $display("FAIL b2b[%0d] err: got %b want %b", n, rsp_err, e.err); miscompares++;
                     end
                     if (rsp_rdata !== e.rdata) begin
                        $display("FAIL b2b[%0d] rdata: got %h want %h", n, rsp_rdata, e.rdata); miscompares++;
                     end
                  end
                  if (acc_cnt - a0 !== n + 1) begin
                     $display("FAIL b2b[%0d] accepts before response: got %0d want %0d", n, acc_cnt - a0, n + 1);
                     miscompares++;
                  end
                  n++;
               end
            end
            vectors++;
            if (n !== 3) begin
               $display("FAIL b2b response count: got %0d want 3", n); miscompares++;
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      vectors += 2;
      if (acc_cnt - a0 !== 3) begin
         $display("FAIL b2b total accepts: got %0d want 3", acc_cnt - a0); miscompares++;
      end
      if (rsp_cnt - r0 !== 3) begin
         $display("FAIL b2b total pulses: got %0d want 3", rsp_cnt - r0); miscompares++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'd0;
      req_signed = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      for (int i = 0; i < 128; i++) poke(i, 8'(i * 5 + 1));
      poke(32'h10, 8'h11);
      poke(32'h11, 8'h22);
      poke(32'h12, 8'h33);
      poke(32'h13, 8'h84);
      poke(32'h14, 8'h55);
      test_loads();
      test_stores();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
